// File: rtl/lcd8080_pkg.sv
// lcd8080_pkg: shared types and constants for the 8080-bus LCD responder.
package lcd8080_pkg;

  localparam int BUS_W      = 16;
  localparam int SYNC_DEPTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_PASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_RDID  = 3'd4
  } state_e;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_RDID    = 8'h04;

endpackage

// File: rtl/lcd8080_responder_if.sv
// lcd8080_responder_if: 8080-style 16-bit LCD bus between host (master) and panel (slave).
interface lcd8080_responder_if;
  import lcd8080_pkg::*;

  logic             lcd_cs_n;
  logic             lcd_wr_n;
  logic             lcd_rd_n;
  logic             lcd_dc_n;
  logic             lcd_lcdreset_n;
  logic [BUS_W-1:0] lcd_data_in;
  logic [BUS_W-1:0] lcd_data_out;
  logic             lcd_data_oe;

  modport master (
    output lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_dc_n, lcd_lcdreset_n, lcd_data_in,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_dc_n, lcd_lcdreset_n, lcd_data_in,
    output lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/lcd8080_sync_edge.sv
// lcd8080_sync_edge: N-bit two-flop synchronizer plus one extra stage for edge detection.
module lcd8080_sync_edge
  import lcd8080_pkg::*;
#(
  parameter int unsigned    N    = 1,
  parameter logic [N-1:0]   INIT = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] q_d,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] sync_p [SYNC_DEPTH];

  // Shift the asynchronous pins through the synchronizer and edge-detect stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_p[i] <= INIT;
    end else begin
      sync_p[0] <= d;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign q    = sync_p[SYNC_DEPTH-2];
  assign q_d  = sync_p[SYNC_DEPTH-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/lcd8080_responder.sv
// lcd8080_responder: panel-side endpoint for the 16-bit 8080 LCD bus.
// Decodes commands, CASET/PASET windows, RAMWR pixel streams and Read-ID.
// Build macro LCD8080_RESP_STATS_EN adds saturating pix_count/cmd_count outputs.
module lcd8080_responder
  import lcd8080_pkg::*;
#(
  parameter int unsigned XW     = 9,
  parameter int unsigned YW     = 9,
  parameter int unsigned XMAX   = 239,
  parameter int unsigned YMAX   = 319,
  parameter logic [23:0] ID_VAL = 24'h009341
) (
  input  logic              clk,
  input  logic              reset_n,
  lcd8080_responder_if.slave bus,
  output logic              pix_valid,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic [15:0]       pix_data,
  output logic              disp_on,
  output logic              proto_err
`ifdef LCD8080_RESP_STATS_EN
  ,
  output logic [31:0]       pix_count,
  output logic [15:0]       cmd_count
`endif
);

  function automatic logic [7:0] rdid_byte(input logic [2:0] idx);
    case (idx)
      3'd1:    return ID_VAL[23:16];
      3'd2:    return ID_VAL[15:8];
      3'd3:    return ID_VAL[7:0];
      default: return 8'h00;
    endcase
  endfunction

  logic [3:0]  ctl_q, ctl_rise, ctl_fall, unused_ctl_q_d;
  logic [16:0] dat_q_d, unused_dat_q, unused_dat_rise, unused_dat_fall;
  logic        unused_edges;

  // control bit order: {lcdreset_n, rd_n, wr_n, cs_n}
  lcd8080_sync_edge #(.N(4), .INIT(4'b1111)) u_sync_ctl (
    .clk(clk), .reset_n(reset_n),
    .d({bus.lcd_lcdreset_n, bus.lcd_rd_n, bus.lcd_wr_n, bus.lcd_cs_n}),
    .q(ctl_q), .q_d(unused_ctl_q_d), .rise(ctl_rise), .fall(ctl_fall)
  );

  lcd8080_sync_edge #(.N(17), .INIT(17'h0)) u_sync_dat (
    .clk(clk), .reset_n(reset_n),
    .d({bus.lcd_dc_n, bus.lcd_data_in}),
    .q(unused_dat_q), .q_d(dat_q_d), .rise(unused_dat_rise), .fall(unused_dat_fall)
  );

  assign unused_edges = ^{ctl_rise[3:2], ctl_rise[0], ctl_fall[3], ctl_fall[1:0]};

  logic cs_s, wr_s, rd_s, lrst_s, wr_evt, rd_evt;
  assign cs_s   = ctl_q[0];
  assign wr_s   = ctl_q[1];
  assign rd_s   = ctl_q[2];
  assign lrst_s = ctl_q[3];
  assign wr_evt = ctl_rise[1] & ~cs_s;
  assign rd_evt = ctl_fall[2] & ~cs_s;

  logic        vld_p3, dc_p3, soft_rst, oe;
  logic [15:0] data_p3, data_out;

  // Stage p3: register the write event; a panel reset drops a write in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    vld_p3 <= 1'b0;
    else if (!lrst_s) vld_p3 <= 1'b0;
    else             vld_p3 <= wr_evt;
  end

  // Stage p3: dc/data captured from the same synchronizer stage as the pre-edge wr_n
  always_ff @(posedge clk) begin
    dc_p3   <= dat_q_d[16];
    data_p3 <= dat_q_d[15:0];
  end

  assign soft_rst = ~lrst_s | (vld_p3 & ~dc_p3 & (data_p3[7:0] == OP_SWRESET));

  state_e        state;
  logic [1:0]    pidx;
  logic [2:0]    rd_idx;
  logic [7:0]    prm_b0, prm_b1, prm_b2;
  logic [XW-1:0] sc, ec, x;
  logic [YW-1:0] sp, ep, y;

  // Command/parameter FSM, pixel address generator, read data and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE; pidx <= '0; rd_idx <= '0;
      prm_b0 <= '0; prm_b1 <= '0; prm_b2 <= '0;
      sc <= '0; ec <= XW'(XMAX); sp <= '0; ep <= YW'(YMAX); x <= '0; y <= '0;
      pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_data <= '0;
      disp_on <= 1'b0; proto_err <= 1'b0; data_out <= '0;
    end else if (soft_rst) begin
      state <= ST_IDLE; pidx <= '0; rd_idx <= '0;
      prm_b0 <= '0; prm_b1 <= '0; prm_b2 <= '0;
      sc <= '0; ec <= XW'(XMAX); sp <= '0; ep <= YW'(YMAX); x <= '0; y <= '0;
      pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_data <= '0;
      disp_on <= 1'b0; proto_err <= 1'b0; data_out <= '0;
    end else begin
      pix_valid <= 1'b0;
      if ((vld_p3 && oe) || (!wr_s && !rd_s && !cs_s)) proto_err <= 1'b1;

      if (rd_evt) begin
        if (state == ST_RDID) begin
          data_out <= {8'h00, rdid_byte(rd_idx)};
          if (rd_idx != 3'd4) rd_idx <= rd_idx + 3'd1;
        end else begin
          data_out <= '0;
        end
      end

      if (vld_p3 && !dc_p3) begin
        // every command aborts whatever sequence was in progress
        state  <= ST_IDLE;
        pidx   <= '0;
        rd_idx <= '0;
        case (data_p3[7:0])
          OP_DISPOFF: disp_on <= 1'b0;
          OP_DISPON:  disp_on <= 1'b1;
          OP_CASET:   state <= ST_CASET;
          OP_PASET:   state <= ST_PASET;
          OP_RDID:    state <= ST_RDID;
          OP_RAMWR: begin
            state <= ST_RAMWR;
            x     <= sc;
            y     <= sp;
          end
          default: ;
        endcase
      end else if (vld_p3) begin
        case (state)
          ST_CASET, ST_PASET: begin
            pidx <= pidx + 2'd1;
            case (pidx)
              2'd0: prm_b0 <= data_p3[7:0];
              2'd1: prm_b1 <= data_p3[7:0];
              2'd2: prm_b2 <= data_p3[7:0];
              default: begin
                // both ends of the window change together on the last byte
                if (state == ST_CASET) begin
                  sc <= XW'({prm_b0, prm_b1});
                  ec <= XW'({prm_b2, data_p3[7:0]});
                end else begin
                  sp <= YW'({prm_b0, prm_b1});
                  ep <= YW'({prm_b2, data_p3[7:0]});
                end
                state <= ST_IDLE;
              end
            endcase
          end
          ST_RAMWR: begin
            pix_valid <= 1'b1;
            pix_x     <= x;
            pix_y     <= y;
            pix_data  <= data_p3;
            if (x == ec) begin
              x <= sc;
              y <= (y == ep) ? sp : y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bus drive enable: set by a qualified read fall, held until rd_n or cs_n rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      oe <= 1'b0;
    else if (soft_rst) oe <= 1'b0;
    else               oe <= (oe | rd_evt) & ~rd_s & ~cs_s;
  end

  assign bus.lcd_data_out = data_out;
  assign bus.lcd_data_oe  = oe;

`ifdef LCD8080_RESP_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_count <= '0;
      cmd_count <= '0;
    end else if (soft_rst) begin
      pix_count <= '0;
      cmd_count <= '0;
    end else begin
      if (pix_valid && (pix_count != '1)) pix_count <= pix_count + 32'd1;
      if (vld_p3 && !dc_p3 && (cmd_count != '1)) cmd_count <= cmd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd8080_responder.sv
// tb_lcd8080_responder: scoreboard bench with a protocol-level reference model.
module tb_lcd8080_responder;

  localparam int M_IDLE = 0, M_CASET = 1, M_PASET = 2, M_RAMWR = 3, M_RDID = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_valid, disp_on, proto_err;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_data;
`ifdef LCD8080_RESP_STATS_EN
  logic [31:0] pix_count;
  logic [15:0] cmd_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [33:0] exp_pix[$];
  logic [15:0] exp_rd[$];

  // reference model state
  int m_mode, m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_np, m_rd;
  int m_prm[4];

  lcd8080_responder_if bus_if();

  lcd8080_responder dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .disp_on(disp_on), .proto_err(proto_err)
`ifdef LCD8080_RESP_STATS_EN
    , .pix_count(pix_count), .cmd_count(cmd_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
    m_x = 0; m_y = 0; m_np = 0; m_rd = 0;
  endtask

  task automatic model_cmd(int op);
    m_mode = M_IDLE;
    if (op == 8'h01) model_reset();
    else if (op == 8'h2A) begin m_mode = M_CASET; m_np = 0; end
    else if (op == 8'h2B) begin m_mode = M_PASET; m_np = 0; end
    else if (op == 8'h2C) begin m_mode = M_RAMWR; m_x = m_sc; m_y = m_sp; end
    else if (op == 8'h04) begin m_mode = M_RDID; m_rd = 0; end
  endtask

  task automatic model_data(logic [15:0] d);
    if (m_mode == M_CASET || m_mode == M_PASET) begin
      m_prm[m_np] = int'(d[7:0]);
      m_np++;
      if (m_np == 4) begin
        int lo_v = (m_prm[0] * 256 + m_prm[1]) % 512;
        int hi_v = (m_prm[2] * 256 + m_prm[3]) % 512;
        if (m_mode == M_CASET) begin m_sc = lo_v; m_ec = hi_v; end
        else begin m_sp = lo_v; m_ep = hi_v; end
        m_mode = M_IDLE;
      end
    end else if (m_mode == M_RAMWR) begin
      exp_pix.push_back({9'(m_x), 9'(m_y), d});
      if (m_x == m_ec) begin
        m_x = m_sc;
        m_y = (m_y == m_ep) ? m_sp : (m_y + 1) % 512;
      end else begin
        m_x = (m_x + 1) % 512;
      end
    end
  endtask

  function automatic logic [15:0] model_read();
    logic [15:0] r;
    r = 16'h0000;
    if (m_mode == M_RDID) begin
      if (m_rd == 1) r = 16'h0000;
      if (m_rd == 2) r = 16'h0093;
      if (m_rd == 3) r = 16'h0041;
      m_rd++;
    end
    return r;
  endfunction

  task automatic bus_write(logic dc, logic [15:0] d);
    bus_if.lcd_dc_n    = dc;
    bus_if.lcd_data_in = d;
    bus_if.lcd_wr_n    = 1'b0;
    tick(4);
    if (dc) model_data(d);
    else    model_cmd(int'(d[7:0]));
    bus_if.lcd_wr_n = 1'b1;
    tick(4);
  endtask

  task automatic bus_cmd(logic [7:0] op);
    bus_write(1'b0, {8'($urandom), op});
  endtask

  task automatic bus_read();
    exp_rd.push_back(model_read());
    bus_if.lcd_rd_n = 1'b0;
    tick(2);
    check("oe_before_3clk", 64'(bus_if.lcd_data_oe), 64'(0));
    tick(1);
    check("oe_at_3clk", 64'(bus_if.lcd_data_oe), 64'(1));
    tick(3);
    bus_if.lcd_rd_n = 1'b1;
    tick(2);
    check("oe_held_after_rise", 64'(bus_if.lcd_data_oe), 64'(1));
    tick(1);
    check("oe_off_3clk", 64'(bus_if.lcd_data_oe), 64'(0));
    tick(2);
  endtask

  task automatic send_window(logic [7:0] op, int lo_v, int hi_v, bit partial);
    bus_cmd(op);
    bus_write(1'b1, {8'($urandom), 8'(((lo_v >> 8) & 1) | ($urandom_range(0, 127) << 1))});
    bus_write(1'b1, {8'($urandom), 8'(lo_v & 255)});
    if (!partial) begin
      bus_write(1'b1, {8'($urandom), 8'(((hi_v >> 8) & 1) | ($urandom_range(0, 127) << 1))});
      bus_write(1'b1, {8'($urandom), 8'(hi_v & 255)});
    end
  endtask

  // Monitor: pixel strobes and read data are checked against the scoreboard queues
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (pix_valid) begin
        if (exp_pix.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pix_unexpected: got x=%0d y=%0d d=%0h expected none", pix_x, pix_y, pix_data);
        end else begin
          check("pix", 64'({pix_x, pix_y, pix_data}), 64'(exp_pix.pop_front()));
        end
      end
      if (bus_if.lcd_data_oe && !oe_prev) begin
        if (exp_rd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected: got %0h expected none", bus_if.lcd_data_out);
        end else begin
          check("rd_data", 64'(bus_if.lcd_data_out), 64'(exp_rd.pop_front()));
        end
      end
    end
    oe_prev = bus_if.lcd_data_oe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.lcd_cs_n = 1'b1; bus_if.lcd_wr_n = 1'b1; bus_if.lcd_rd_n = 1'b1;
    bus_if.lcd_dc_n = 1'b1; bus_if.lcd_lcdreset_n = 1'b1; bus_if.lcd_data_in = 16'h0;
    reset_n = 1'b0;
    model_reset();
    tick(4);
    check("rst_pix_valid", 64'(pix_valid), 64'(0));
    check("rst_oe", 64'(bus_if.lcd_data_oe), 64'(0));
    reset_n = 1'b1;
    tick(2);
    check("rst_outputs", 64'({pix_x, pix_y, pix_data, disp_on, proto_err}), 64'(0));
    check("rst_data_out", 64'(bus_if.lcd_data_out), 64'(0));
    bus_if.lcd_cs_n = 1'b0;
    tick(2);

    // default window streaming
    bus_cmd(8'h2C);
    bus_write(1'b1, 16'hF800);
    bus_write(1'b1, 16'h07E0);
    bus_write(1'b1, 16'h001F);

    // small window with column and frame wrap
    send_window(8'h2A, 10, 11, 1'b0);
    send_window(8'h2B, 5, 6, 1'b0);
    bus_cmd(8'h2C);
    for (int i = 0; i < 5; i++) bus_write(1'b1, 16'($urandom));
    tick(4);
    check("pix_drained_1", 64'(exp_pix.size()), 64'(0));

    // Read-ID sequence, one extra read, then a read outside RDID
    bus_cmd(8'h04);
    for (int i = 0; i < 5; i++) bus_read();
    bus_cmd(8'h00);
    bus_read();

    // display on/off
    bus_cmd(8'h29);
    check("disp_on", 64'(disp_on), 64'(1));
    bus_cmd(8'h28);
    check("disp_off", 64'(disp_on), 64'(0));

    // incomplete CASET leaves the default window in place
    bus_cmd(8'h01);
    send_window(8'h2A, 100, 120, 1'b1);
    bus_cmd(8'h2C);
    bus_write(1'b1, 16'h1234);
    bus_write(1'b1, 16'h5678);

    // randomized windows, stray data and unknown opcodes
    for (int it = 0; it < 8; it++) begin
      int sc_r = $urandom_range(0, 511);
      int ec_r = (it % 4 == 3) ? (sc_r + 509) % 512 : (sc_r + $urandom_range(0, 3)) % 512;
      int sp_r = $urandom_range(0, 511);
      int ep_r = (sp_r + $urandom_range(0, 3)) % 512;
      send_window(8'h2A, sc_r, ec_r, (it == 2));
      send_window(8'h2B, sp_r, ep_r, 1'b0);
      if (it % 3 == 1) begin
        bus_write(1'b1, 16'($urandom));
        bus_cmd(8'h3A);
        bus_write(1'b1, 16'($urandom));
      end
      bus_cmd(8'h2C);
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) bus_write(1'b1, 16'($urandom));
    end
    tick(4);
    check("pix_drained_rand", 64'(exp_pix.size()), 64'(0));

    // panel reset while a pixel write is in flight
    bus_cmd(8'h29);
    send_window(8'h2A, 20, 30, 1'b0);
    bus_cmd(8'h2C);
    bus_write(1'b1, 16'hAAAA);
    bus_write(1'b1, 16'hBBBB);
    bus_if.lcd_dc_n = 1'b1;
    bus_if.lcd_data_in = 16'hCCCC;
    bus_if.lcd_wr_n = 1'b0;
    tick(4);
    bus_if.lcd_wr_n = 1'b1;
    bus_if.lcd_lcdreset_n = 1'b0;
    tick(4);
    bus_if.lcd_lcdreset_n = 1'b1;
    model_reset();
    tick(6);
    check("lrst_disp_off", 64'(disp_on), 64'(0));
    bus_write(1'b1, 16'hDDDD);
    bus_write(1'b1, 16'hEEEE);
    tick(4);
    check("lrst_no_pix", 64'(exp_pix.size()), 64'(0));
    bus_cmd(8'h2C);
    bus_write(1'b1, 16'h0F0F);

    // wr_n and rd_n low together, sticky until SWRESET
    bus_cmd(8'h00);
    check("proto_clear", 64'(proto_err), 64'(0));
    exp_rd.push_back(model_read());
    bus_if.lcd_dc_n = 1'b1;
    bus_if.lcd_data_in = 16'h4321;
    bus_if.lcd_wr_n = 1'b0;
    bus_if.lcd_rd_n = 1'b0;
    tick(6);
    check("proto_set", 64'(proto_err), 64'(1));
    model_data(16'h4321);
    bus_if.lcd_wr_n = 1'b1;
    bus_if.lcd_rd_n = 1'b1;
    tick(6);
    bus_cmd(8'h00);
    check("proto_sticky", 64'(proto_err), 64'(1));
    bus_cmd(8'h01);
    check("proto_swreset", 64'(proto_err), 64'(0));

    tick(10);
    check("pix_queue_empty", 64'(exp_pix.size()), 64'(0));
    check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
